uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal 1..8).
REQ-002 Parameter DATA_WIDTH, default 8, byte width passed to the transmitter.
REQ-003 Parameter LOCK_TIMEOUT, default 1024, idle cycles allowed in LOCKED state before forced release.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_lock  input  NUM_REQ  per-requester request to keep grant across consecutive bytes (packet mode).
REQ-010 req_ready  output  NUM_REQ  per-requester accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-011 tx_data  output  DATA_WIDTH  byte presented to transmitter.
REQ-012 tx_valid  output  1  byte present for transmitter.
REQ-013 tx_ready  input  1  transmitter can accept; transfer on tx_valid and tx_ready.
REQ-014 grant_id  output  $clog2(NUM_REQ) (min 1)  index of current owner.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 lock_timeout  output  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-017 FSM states: IDLE, SEND, LOCKED; encoding from the shared package.
REQ-018 IDLE: req_ready[w] high combinationally for round-robin winner w among req_valid, searching from rr_ptr upward with wrap; all others low.
REQ-019 IDLE with any req_valid: capture req_data[w] into hold register, owner<=w, go SEND; no req_valid: stay IDLE.
REQ-020 Latency: byte accepted from requester in cycle N appears with tx_valid=1 in cycle N+1.
REQ-021 SEND: tx_valid=1, tx_data=hold register, all req_ready low; tx_data stable until transfer.
REQ-022 SEND with tx_ready=0: remain SEND indefinitely.
REQ-023 SEND with tx_ready=1: if req_lock[owner]=1 go LOCKED, else go IDLE with rr_ptr<=owner+1 modulo NUM_REQ.
REQ-024 LOCKED: tx_valid=0; req_ready[owner] high, others low; timeout counter increments each cycle, cleared on entry.
REQ-025 LOCKED with req_valid[owner]: capture byte, go SEND (lock honoured even if req_lock dropped same cycle).
REQ-026 LOCKED with req_lock[owner]=0 and no req_valid[owner]: go IDLE, rr_ptr<=owner+1.
REQ-027 LOCKED with counter reaching LOCK_TIMEOUT-1 and no req_valid[owner]: go IDLE, rr_ptr<=owner+1, pulse lock_timeout.
REQ-028 grant_id reflects owner in SEND/LOCKED and equals rr_ptr in IDLE.
REQ-029 Simultaneous requests: exactly one grant per arbitration; after release, a requester is skipped at most NUM_REQ-1 times.
REQ-030 NUM_REQ=1: rr_ptr stays 0; behaviour otherwise identical.
REQ-031 tx_ready toggling while not in SEND has no effect.

Reset
REQ-032 reset_n low at a rising edge: state<=IDLE, rr_ptr<=0, owner<=0, hold register<=0, timeout counter<=0.
REQ-033 During and immediately after reset: req_ready=0 for all bits while reset_n low, tx_valid=0, tx_data=0, grant_id=0, busy=0, lock_timeout=0.
REQ-034 Reset asserted mid-SEND discards the held byte; no byte is re-presented after reset.

Structure
REQ-035 Shared package uart_pkg holds arbiter state typedef/localparams and default DATA_WIDTH.
REQ-036 One combinational sub-module rr_pick (inputs request vector and pointer; output one-hot grant and index) implements the round-robin search.

Verification
REQ-037 Single request: req_valid=4'b0100, data 0x5A, tx_ready=1 -> req_ready[2] pulses, next cycle tx_valid=1 tx_data=0x5A grant_id=2, then IDLE, rr_ptr=3.
REQ-038 All four request continuously, no lock -> bytes from requesters 0,1,2,3,0 in that order, one per SEND.
REQ-039 Backpressure: tx_ready held 0 for 20 cycles in SEND -> tx_valid and tx_data stable 20 cycles, transfer on cycle tx_ready=1.
REQ-040 Lock: requester 1 sends 3 bytes with req_lock=1 while requester 0 requests -> 3 bytes from 1 contiguous, then requester 2 or 0 per rr_ptr=2 search.
REQ-041 Timeout: LOCK_TIMEOUT=16, requester 3 locks then idles -> lock_timeout pulses 16 cycles after LOCKED entry, state IDLE.
REQ-042 Reset mid-SEND with tx_ready=0 -> next cycle tx_valid=0, busy=0, grant_id=0; subsequent request arbitrated from index 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding
// and the default byte width handed to the transmitter.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_SEND   = 2'd1;
    localparam arb_state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: picks the first asserted request at or
// above ptr, wrapping to the lowest asserted request below ptr.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic             hi_any;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scan so the final hit is the lowest index in each half.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        any    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any    = 1'b1;
                lo_idx = IDX_W'(i);
            end
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                hi_any = 1'b1;
                hi_idx = IDX_W'(i);
            end
        end
        idx = hi_any ? hi_idx : lo_idx;
    end

    // One-hot view of the chosen index, empty when nothing requests.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// sources, with an optional packet lock that keeps the grant across
// consecutive bytes and a timeout that forcibly releases an idle lock.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter  int LOCK_TIMEOUT = 1024,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy,
    output logic                          lock_timeout
);

    localparam int               CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      owner;
    logic [DATA_WIDTH-1:0] hold;
    logic [CNT_W-1:0]      tcnt;
    logic                  timeout_q;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] pick_data;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  owner_valid;
    logic                  owner_lock;
    logic [IDX_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]    owner_oh;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_data   = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    assign owner_data  = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
    assign owner_valid = req_valid[owner];
    assign owner_lock  = req_lock[owner];
    // Pointer moves one past the releasing owner so it is searched last next time.
    assign next_ptr    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // One-hot select of the current owner for packet-mode accepts.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner == IDX_W'(i));
        end
    end

    // FSM, hold register, round-robin pointer and lock idle counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            hold      <= '0;
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        hold  <= pick_data;
                        owner <= pick_idx;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (owner_lock) begin
                            state <= ST_LOCKED;
                            tcnt  <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A pending byte wins even if the lock request drops this cycle.
                    if (owner_valid) begin
                        hold  <= owner_data;
                        state <= ST_SEND;
                    end else if (!owner_lock) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                    end else if (tcnt == CNT_LAST) begin
                        state     <= ST_IDLE;
                        rr_ptr    <= next_ptr;
                        timeout_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; everything is forced quiet while reset_n is low.
    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        grant_id  = '0;
        busy      = 1'b0;
        if (reset_n) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    req_ready = pick_grant;
                    grant_id  = rr_ptr;
                end
                ST_SEND: begin
                    tx_valid = 1'b1;
                    tx_data  = hold;
                    grant_id = owner;
                end
                ST_LOCKED: begin
                    req_ready = owner_oh;
                    grant_id  = owner;
                end
                default: begin
                    grant_id = rr_ptr;
                end
            endcase
        end
    end

    assign lock_timeout = reset_n & timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level reference
// model checked every cycle, plus directed scenarios with literal values.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LT = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            lock_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_lock     (req_lock),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int xg[$];
    int xd[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who is sending, who holds a lock, and where the search starts.
    bit m_send, m_lock, m_to;
    int m_owner, m_ptr, m_hold, m_idle;

    // Winner = valid requester with the smallest forward distance from ptr.
    function automatic int rr_win(input logic [N-1:0] v, input int ptr);
        int best, bd, d;
        best = -1;
        bd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - ptr + N) % N;
            if (v[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic int byte_of(input int i);
        return int'(req_data[i*DW +: DW]);
    endfunction

    always @(posedge clk) begin : model
        int w;
        if (!reset_n) begin
            m_send = 0; m_lock = 0; m_to = 0;
            m_owner = 0; m_ptr = 0; m_hold = 0; m_idle = 0;
        end else begin
            m_to = 0;
            if (m_send) begin
                if (tx_ready) begin
                    m_send = 0;
                    if (req_lock[m_owner]) begin
                        m_lock = 1;
                        m_idle = 0;
                    end else begin
                        m_ptr = (m_owner + 1) % N;
                    end
                end
            end else if (m_lock) begin
                if (req_valid[m_owner]) begin
                    m_hold = byte_of(m_owner);
                    m_lock = 0;
                    m_send = 1;
                end else if (!req_lock[m_owner]) begin
                    m_lock = 0;
                    m_ptr = (m_owner + 1) % N;
                end else if (m_idle == LT - 1) begin
                    m_lock = 0;
                    m_ptr = (m_owner + 1) % N;
                    m_to = 1;
                end else begin
                    m_idle++;
                end
            end else begin
                w = rr_win(req_valid, m_ptr);
                if (w >= 0) begin
                    m_hold = byte_of(w);
                    m_owner = w;
                    m_send = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] er;
        int w;
        if (!reset_n) begin
            chk("req_ready", 64'(req_ready), 64'(0));
            chk("tx_valid", 64'(tx_valid), 64'(0));
            chk("tx_data", 64'(tx_data), 64'(0));
            chk("grant_id", 64'(grant_id), 64'(0));
            chk("busy", 64'(busy), 64'(0));
            chk("lock_timeout", 64'(lock_timeout), 64'(0));
        end else begin
            er = '0;
            if (m_lock) er[m_owner] = 1'b1;
            else if (!m_send) begin
                w = rr_win(req_valid, m_ptr);
                if (w >= 0) er[w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("tx_valid", 64'(tx_valid), 64'(m_send));
            chk("tx_data", 64'(tx_data), 64'(m_send ? m_hold : 0));
            chk("grant_id", 64'(grant_id), 64'((m_send || m_lock) ? m_owner : m_ptr));
            chk("busy", 64'(busy), 64'(m_send || m_lock));
            chk("lock_timeout", 64'(lock_timeout), 64'(m_to));
            if (tx_valid && tx_ready) begin
                xg.push_back(int'(grant_id));
                xd.push_back(int'(tx_data));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        tx_ready = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        while (xg.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (xg.size() < n) chk("xfer_wait_expired", 64'(xg.size()), 64'(n));
    endtask

    initial begin : main
        int cnt, budget;
        int exp_o[5];
        int exp_d[5];

        // Reset: outputs quiet while reset_n is low even with all requesting.
        req_valid = '1; req_lock = '1; tx_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        cyc(2);
        @(negedge clk);
        chk("rst_req_ready2", 64'(req_ready), 64'(0));
        cyc(0);
        reset_n = 1'b1; req_valid = '0; req_lock = '0;
        @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        cyc(1);

        // Single request from requester 2.
        req_valid = 4'b0100; req_data = 32'h005A_0000; tx_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        cyc(1);
        req_valid = '0;
        @(negedge clk);
        chk("single_tx_valid", 64'(tx_valid), 64'(1));
        chk("single_tx_data", 64'(tx_data), 64'(8'h5A));
        chk("single_grant", 64'(grant_id), 64'(2));
        cyc(1);
        @(negedge clk);
        chk("single_idle_busy", 64'(busy), 64'(0));
        chk("single_rr_ptr", 64'(grant_id), 64'(3));
        cyc(1);

        // All four requesting without lock: strict rotation from 0.
        do_reset();
        req_data = 32'h1312_1110; req_valid = '1; tx_ready = 1'b1;
        xg.delete(); xd.delete();
        wait_xfers(5, 40);
        exp_o = '{0, 1, 2, 3, 0};
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        if (xg.size() >= 5)
            for (int k = 0; k < 5; k++) begin
                chk("rotate_owner", 64'(xg[k]), 64'(exp_o[k]));
                chk("rotate_data", 64'(xd[k]), 64'(exp_d[k]));
            end
        req_valid = '0;
        cyc(3);

        // Backpressure: byte held stable for 20 stalled cycles.
        do_reset();
        tx_ready = 1'b0; req_valid = 4'b0010; req_data = 32'h0000_C300;
        cyc(1);
        req_valid = '0; req_data = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_tx_valid", 64'(tx_valid), 64'(1));
            chk("bp_tx_data", 64'(tx_data), 64'(8'hC3));
            cyc(1);
        end
        xg.delete(); xd.delete();
        tx_ready = 1'b1;
        cyc(1);
        chk("bp_xfer_count", 64'(xg.size()), 64'(1));
        if (xd.size() >= 1) chk("bp_xfer_data", 64'(xd[0]), 64'(8'hC3));
        @(negedge clk);
        chk("bp_after_valid", 64'(tx_valid), 64'(0));
        cyc(1);

        // Packet lock: requester 1 keeps the grant for 3 bytes while 0 waits.
        do_reset();
        tx_ready = 1'b1; req_data = 32'h0000_B1A0; req_valid = 4'b0001;
        xg.delete(); xd.delete();
        cyc(1);
        req_valid = 4'b0011; req_lock = 4'b0010;
        cnt = 0; budget = 60;
        while (cnt < 3 && budget > 0) begin
            @(negedge clk);
            if (req_ready[1]) cnt++;
            cyc(1);
            budget--;
        end
        if (cnt < 3) chk("lock_accept_wait_expired", 64'(cnt), 64'(3));
        req_valid = 4'b0001; req_lock = '0;
        wait_xfers(5, 40);
        exp_o = '{0, 1, 1, 1, 0};
        if (xg.size() >= 5)
            for (int k = 0; k < 5; k++) chk("lock_owner", 64'(xg[k]), 64'(exp_o[k]));
        req_valid = '0;
        cyc(3);

        // Lock timeout: requester 3 locks then goes silent.
        do_reset();
        tx_ready = 1'b1; req_valid = 4'b1000; req_lock = 4'b1000; req_data = 32'h3C00_0000;
        cyc(1);
        req_valid = '0;
        cyc(1);
        for (int k = 0; k < LT; k++) begin
            @(negedge clk);
            chk("to_pending_pulse", 64'(lock_timeout), 64'(0));
            chk("to_pending_busy", 64'(busy), 64'(1));
            chk("to_pending_ready", 64'(req_ready), 64'(4'b1000));
            cyc(0);
            tx_ready = 1'($urandom);
            cyc(1);
        end
        @(negedge clk);
        chk("to_pulse", 64'(lock_timeout), 64'(1));
        chk("to_busy", 64'(busy), 64'(0));
        chk("to_rr_ptr", 64'(grant_id), 64'(0));
        cyc(1);
        @(negedge clk);
        chk("to_pulse_end", 64'(lock_timeout), 64'(0));
        cyc(1);
        req_lock = '0;

        // Reset in the middle of a stalled SEND.
        do_reset();
        tx_ready = 1'b0; req_valid = 4'b0100; req_data = 32'h0077_0000;
        cyc(1);
        req_valid = '0;
        cyc(3);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_tx_valid", 64'(tx_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_grant", 64'(grant_id), 64'(0));
        cyc(1);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("midrst_arb_from0", 64'(req_ready), 64'(4'b0010));
        cyc(1);
        req_valid = '0; tx_ready = 1'b1;
        cyc(3);

        // Randomized traffic, alternating free-running and sticky-lock phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_data = {$urandom};
            tx_ready = ($urandom_range(0, 3) != 0);
            if (((i / 250) % 2) == 1) begin
                req_lock = '1;
                req_valid = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            end else begin
                req_lock = N'($urandom & $urandom);
                req_valid = N'($urandom);
            end
            reset_n = ($urandom_range(0, 199) != 0);
            cyc(1);
        end
        reset_n = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
